// File: rtl/l1_mem_arbiter.sv
// Line-granular arbiter joining the L1 I-cache and D-cache onto one memory port.
// Optional ARB_ROUND_ROBIN_EN: alternate winners on simultaneous requests.
module l1_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              win_d_q, win_d_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;

  logic              i_req, d_req, any_req;
  logic              pick_d;
  logic [ADDR_W-1:0] sel_addr;

  assign i_req   = i_read | i_write;
  assign d_req   = d_read | d_write;
  assign any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Last winner: 0 = I-port, 1 = D-port.
  logic last_d_q, last_d_d;
  assign pick_d = d_req & (~i_req | ~last_d_q);
`else
  assign pick_d = d_req;
`endif

  assign sel_addr = pick_d ? d_addr : i_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      win_d_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      i_cnt_q     <= '0;
      d_cnt_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      win_d_q     <= win_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
      i_cnt_q     <= i_cnt_d;
      d_cnt_q     <= d_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (mem_resp) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    win_d_d     = win_d_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_resp_d    = 1'b0;
    d_resp_d    = 1'b0;
    i_cnt_d     = i_cnt_q;
    d_cnt_d     = d_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d_d     = pick_d;
          mem_read_d  = pick_d ? d_read : i_read;
          mem_write_d = pick_d ? d_write : i_write;
          mem_addr_d  = sel_addr & ~ADDR_W'(5'h1f);
          mem_wdata_d = pick_d ? d_wdata : i_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d    = pick_d;
`endif
        end
      end
      BUSY: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          // Writes leave the winner's rdata register untouched.
          if (win_d_q) begin
            d_resp_d = 1'b1;
            d_cnt_d  = d_cnt_q + CNT_W'(1);
            if (mem_read_q) d_rdata_d = mem_rdata;
          end else begin
            i_resp_d = 1'b1;
            i_cnt_d  = i_cnt_q + CNT_W'(1);
            if (mem_read_q) i_rdata_d = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign i_resp      = i_resp_q;
  assign d_resp      = d_resp_q;
  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

endmodule
